ofdm_cp_remove: RTL and testbench

Receive-side cyclic-prefix stripper for the OFDM chain. It sits ahead of the receiver FFT and takes the same framed complex sample stream that the transmit IFFT+CP stage emits: 12 symbols of 16 CP + 256 data samples, 3264 samples per frame. It discards each symbol's CP and forwards the 256 useful samples with symbol framing markers. A gap watchdog aborts a stalled frame.

---
 rtl/ofdm_cp_remove.sv | 178 +++++++++++++++++
 tb/tb_ofdm_cp_remove.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/ofdm_cp_remove.sv
// ofdm_cp_remove
//   Receive-side cyclic-prefix stripper. Takes framed complex samples
//   (NSYM symbols of NCP prefix + NFFT useful samples), drops each prefix
//   and forwards the useful samples with symbol framing markers after one
//   register stage. A gap watchdog aborts a frame that stalls inside CP/DATA.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   di_re/di_im/di_vld  input sample stream, no backpressure
//   do_re/do_im/do_vld  forwarded useful samples (data holds when do_vld=0)
//   do_sos/do_eos       first / last useful sample of a symbol
//   do_sym_idx          symbol index within the frame, valid with do_vld
//   frm_done            pulse together with the final do_eos of a frame
//   err_gap             pulse when a frame is aborted by the gap watchdog
module ofdm_cp_remove #(
    parameter int DW      = 12,
    parameter int NFFT    = 256,
    parameter int NCP     = 16,
    parameter int NSYM    = 12,
    parameter int GAP_MAX = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] di_re,
    input  logic [DW-1:0] di_im,
    input  logic          di_vld,
    output logic [DW-1:0] do_re,
    output logic [DW-1:0] do_im,
    output logic          do_vld,
    output logic          do_sos,
    output logic          do_eos,
    output logic [3:0]    do_sym_idx,
    output logic          frm_done,
    output logic          err_gap
);

    localparam int SW = $clog2(NFFT + NCP);
    localparam int GW = $clog2(GAP_MAX + 1);

    localparam logic [SW-1:0] CP_LAST    = SW'(NCP - 1);
    localparam logic [SW-1:0] DATA_FIRST = SW'(NCP);
    localparam logic [SW-1:0] SMP_LAST   = SW'(NFFT + NCP - 1);
    localparam logic [3:0]    SYM_LAST   = 4'(NSYM - 1);
    // Abort fires when the GAP_MAX-th consecutive idle cycle is seen, i.e.
    // while the count still holds GAP_MAX-1 and di_vld is low again.
    localparam logic [GW-1:0] GAP_LIM    = GW'(GAP_MAX - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CP,
        S_DATA
    } state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] smp_q, smp_d;
    logic [3:0]    sym_q, sym_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [DW-1:0] re_q, re_d;
    logic [DW-1:0] im_q, im_d;
    logic          vld_q, vld_d;
    logic          sos_q, sos_d;
    logic          eos_q, eos_d;
    logic [3:0]    idx_q, idx_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            smp_q   <= '0;
            sym_q   <= '0;
            gap_q   <= '0;
            re_q    <= '0;
            im_q    <= '0;
            vld_q   <= 1'b0;
            sos_q   <= 1'b0;
            eos_q   <= 1'b0;
            idx_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            smp_q   <= smp_d;
            sym_q   <= sym_d;
            gap_q   <= gap_d;
            re_q    <= re_d;
            im_q    <= im_d;
            vld_q   <= vld_d;
            sos_q   <= sos_d;
            eos_q   <= eos_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        smp_d   = smp_q;
        sym_d   = sym_q;
        gap_d   = gap_q;
        re_d    = re_q;
        im_d    = im_q;
        vld_d   = 1'b0;
        sos_d   = 1'b0;
        eos_d   = 1'b0;
        idx_d   = idx_q;
        done_d  = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                // First valid sample is CP sample 0 of symbol 0.
                if (di_vld) begin
                    smp_d   = SW'(1);
                    gap_d   = '0;
                    state_d = (CP_LAST == '0) ? S_DATA : S_CP;
                end
            end

            S_CP, S_DATA: begin
                if (!di_vld) begin
                    if (gap_q == GAP_LIM) begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                        smp_d   = '0;
                        sym_d   = '0;
                        gap_d   = '0;
                    end else begin
                        gap_d = gap_q + GW'(1);
                    end
                end else begin
                    gap_d = '0;
                    if (state_q == S_CP) begin
                        smp_d = smp_q + SW'(1);
                        if (smp_q == CP_LAST) begin
                            state_d = S_DATA;
                        end
                    end else begin
                        vld_d = 1'b1;
                        re_d  = di_re;
                        im_d  = di_im;
                        idx_d = sym_q;
                        sos_d = (smp_q == DATA_FIRST);
                        if (smp_q == SMP_LAST) begin
                            eos_d = 1'b1;
                            smp_d = '0;
                            if (sym_q == SYM_LAST) begin
                                sym_d   = '0;
                                done_d  = 1'b1;
                                state_d = S_IDLE;
                            end else begin
                                sym_d   = sym_q + 4'd1;
                                state_d = S_CP;
                            end
                        end else begin
                            smp_d = smp_q + SW'(1);
                        end
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign do_re      = re_q;
    assign do_im      = im_q;
    assign do_vld     = vld_q;
    assign do_sos     = sos_q;
    assign do_eos     = eos_q;
    assign do_sym_idx = idx_q;
    assign frm_done   = done_q;
    assign err_gap    = err_q;

endmodule

// File: tb/tb_ofdm_cp_remove.sv
// Testbench for ofdm_cp_remove: table of frame-level scenarios plus
// hand-written reset and idle sequences, with a per-cycle expected-output
// model derived from the frame layout.
module tb_ofdm_cp_remove;

    localparam int DW      = 12;
    localparam int NFFT    = 256;
    localparam int NCP     = 16;
    localparam int NSYM    = 12;
    localparam int GAP_MAX = 64;
    localparam int SYML    = NFFT + NCP;
    localparam int FRML    = SYML * NSYM;

    logic          clk;
    logic          rst_n;
    logic [DW-1:0] di_re, di_im;
    logic          di_vld;
    logic [DW-1:0] do_re, do_im;
    logic          do_vld, do_sos, do_eos;
    logic [3:0]    do_sym_idx;
    logic          frm_done, err_gap;

    ofdm_cp_remove #(
        .DW(DW), .NFFT(NFFT), .NCP(NCP), .NSYM(NSYM), .GAP_MAX(GAP_MAX)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .di_re(di_re), .di_im(di_im), .di_vld(di_vld),
        .do_re(do_re), .do_im(do_im), .do_vld(do_vld),
        .do_sos(do_sos), .do_eos(do_eos), .do_sym_idx(do_sym_idx),
        .frm_done(frm_done), .err_gap(err_gap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic          vld;
        logic [DW-1:0] re;
        logic [DW-1:0] im;
        logic          sos;
        logic          eos;
        logic [3:0]    sym;
        logic          done;
        logic          err;
    } exp_t;

    typedef struct {
        string name;
        int    nframes;
        int    gap1_at;    // sample index in frame 0 preceded by gap1 (-1: none)
        int    gap1_len;
        int    gap2_at;
        int    gap2_len;
        int    exp_vld;
        int    exp_done;
        int    exp_err;
    } scen_t;

    exp_t exp_nxt;
    int   n_cmp, n_bad;
    int   n_vld, n_done, n_err;

    task automatic chk(input string name, input int act, input int expv);
        n_cmp++;
        if (act != expv) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, expv);
        end
    endtask

    // Expected output is whatever the input captured at this edge implies.
    always begin
        exp_t cur;
        @(posedge clk);
        cur = exp_nxt;
        #1;
        chk("do_vld", int'(do_vld), int'(cur.vld));
        if (cur.vld) begin
            chk("do_re", int'(do_re), int'(cur.re));
            chk("do_im", int'(do_im), int'(cur.im));
            chk("do_sym_idx", int'(do_sym_idx), int'(cur.sym));
        end
        chk("do_sos", int'(do_sos), int'(cur.sos));
        chk("do_eos", int'(do_eos), int'(cur.eos));
        chk("frm_done", int'(frm_done), int'(cur.done));
        chk("err_gap", int'(err_gap), int'(cur.err));
        n_vld  += int'(do_vld);
        n_done += int'(frm_done);
        n_err  += int'(err_gap);
    end

    task automatic drive_smp(input int tag, input int i);
        int   val, p;
        exp_t e;
        @(negedge clk);
        val    = tag * 1000 + i;
        di_re  = DW'(val);
        di_im  = DW'(-val);
        di_vld = 1'b1;
        p      = i % SYML;
        e      = '0;
        if (p >= NCP) begin
            e.vld  = 1'b1;
            e.re   = DW'(val);
            e.im   = DW'(-val);
            e.sos  = (p == NCP);
            e.eos  = (p == SYML - 1);
            e.sym  = 4'(i / SYML);
            e.done = (i == FRML - 1);
        end
        exp_nxt = e;
    endtask

    task automatic drive_gap(input int len);
        exp_t e;
        for (int c = 1; c <= len; c++) begin
            @(negedge clk);
            di_vld = 1'b0;
            di_re  = 12'h5A5;
            di_im  = 12'hA5A;
            e      = '0;
            e.err  = (c == GAP_MAX);
            exp_nxt = e;
        end
    endtask

    task automatic clear_counts();
        @(negedge clk);
        n_vld  = 0;
        n_done = 0;
        n_err  = 0;
    endtask

    scen_t sc[4];

    initial begin
        sc[0] = '{"contig",   1, -1,   0,   -1,   0, 3072, 1, 0};
        sc[1] = '{"b2b",      2, -1,   0,   -1,   0, 6144, 2, 0};
        sc[2] = '{"gaps",     1, 1460, 10,  1909, 63, 3072, 1, 0};
        sc[3] = '{"abort",    2, 1000, 64,  -1,   0, 936 + 3072, 1, 1};

        n_cmp = 0; n_bad = 0;
        n_vld = 0; n_done = 0; n_err = 0;
        rst_n = 1'b0; di_vld = 1'b0; di_re = '0; di_im = '0;
        exp_nxt = '0;

        repeat (3) @(negedge clk);
        chk("rst_do_re", int'(do_re), 0);
        chk("rst_do_im", int'(do_im), 0);
        chk("rst_sym_idx", int'(do_sym_idx), 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int s = 0; s < 4; s++) begin
            clear_counts();
            for (int f = 0; f < sc[s].nframes; f++) begin
                for (int i = 0; i < FRML; i++) begin
                    if (f == 0 && i == sc[s].gap2_at) drive_gap(sc[s].gap2_len);
                    if (f == 0 && i == sc[s].gap1_at) begin
                        drive_gap(sc[s].gap1_len);
                        if (sc[s].gap1_len >= GAP_MAX) break;
                    end
                    drive_smp(s * 2 + f, i);
                end
            end
            drive_gap(5);
            @(negedge clk);
            chk({sc[s].name, "_nvld"}, n_vld, sc[s].exp_vld);
            chk({sc[s].name, "_ndone"}, n_done, sc[s].exp_done);
            chk({sc[s].name, "_nerr"}, n_err, sc[s].exp_err);
        end

        // Reset in the middle of a frame, then a fresh frame.
        clear_counts();
        for (int i = 0; i < 500; i++) drive_smp(3, i);
        @(negedge clk);
        rst_n   = 1'b0;
        di_vld  = 1'b0;
        exp_nxt = '0;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("midrst_do_re", int'(do_re), 0);
            chk("midrst_do_im", int'(do_im), 0);
            chk("midrst_sym_idx", int'(do_sym_idx), 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        clear_counts();
        for (int i = 0; i < FRML; i++) drive_smp(1, i);
        drive_gap(5);
        @(negedge clk);
        chk("postrst_nvld", n_vld, 3072);
        chk("postrst_ndone", n_done, 1);
        chk("postrst_nerr", n_err, 0);

        // Long idle stretch in IDLE: watchdog must stay quiet.
        clear_counts();
        drive_gap(GAP_MAX - 1);
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            di_vld  = 1'b0;
            exp_nxt = '0;
        end
        @(negedge clk);
        chk("idle_nvld", n_vld, 0);
        chk("idle_nerr", n_err, 0);
        chk("idle_ndone", n_done, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
